// File: rtl/data_loader_pkg.sv
// Shared definitions for the data loader controller: state encoding and
// default pass geometry.
package data_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RD_INIT = 3'd3,
    ST_READ    = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  localparam int N_SAMPLES_DEF = 150;
  localparam int N_PASSES_DEF  = 4;

endpackage

// File: rtl/data_loader_ctrl.sv
// Data loader controller: fills the x/y sample memories from an upstream
// valid/ready stream, then streams them back out through a downstream
// valid/ready port. The datapath owns the sample counter; this block only
// clears it (init_cn), advances it (count_en) and watches its terminal flag (co).
// Optional build macro DL_MULTI_PASS_EN: repeat the read pass N_PASSES times.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for start, all outputs low
// ST_INIT    | clear datapath counter before loading
// ST_LOAD    | accept upstream samples, write x/y, advance counter
// ST_RD_INIT | clear datapath counter before a read pass
// ST_READ    | present x/y downstream, advance counter on handshake
// ST_FIN     | one-cycle done pulse, then back to idle
module data_loader_ctrl
  import data_loader_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int N_PASSES  = N_PASSES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  input  logic co,
  output logic init_cn,
  output logic count_en,
  output logic x_write,
  output logic y_write,
  output logic x_read,
  output logic y_read,
  output logic busy,
  output logic done
);

  // The terminal index is decoded in the datapath (co), so the sample count
  // only needs to be sane here.
  if (N_SAMPLES < 2 || N_PASSES < 1) begin : g_param_check
    $error("data_loader_ctrl: N_SAMPLES must be >= 2 and N_PASSES >= 1");
  end

  state_t state;
  logic   last_pass;

`ifdef DL_MULTI_PASS_EN
  localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  logic [PW-1:0] pass_cnt;

  // Count completed read passes; restart the count at the beginning of a run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
    end else if (state == ST_INIT) begin
      pass_cnt <= '0;
    end else if (state == ST_READ && out_ready && co && !last_pass) begin
      pass_cnt <= pass_cnt + 1'b1;
    end
  end

  assign last_pass = (pass_cnt == PW'(N_PASSES - 1));
`else
  assign last_pass = 1'b1;
`endif

  // State register: load once, read one or more passes, pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state <= ST_INIT;
        ST_INIT:    state <= ST_LOAD;
        ST_LOAD:    if (in_valid && co) state <= ST_RD_INIT;
        ST_RD_INIT: state <= ST_READ;
        ST_READ:    if (out_ready && co) state <= last_pass ? ST_FIN : ST_RD_INIT;
        ST_FIN:     state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Output decode; write/read strobes follow the handshake inputs in the same
  // cycle so the counter and memories move only on accepted beats.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    init_cn   = 1'b0;
    count_en  = 1'b0;
    x_write   = 1'b0;
    y_write   = 1'b0;
    x_read    = 1'b0;
    y_read    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_INIT: begin
        init_cn = 1'b1;
        busy    = 1'b1;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        x_write  = in_valid;
        y_write  = in_valid;
        count_en = in_valid;
        busy     = 1'b1;
      end
      ST_RD_INIT: begin
        init_cn = 1'b1;
        busy    = 1'b1;
      end
      ST_READ: begin
        out_valid = 1'b1;
        x_read    = 1'b1;
        y_read    = 1'b1;
        count_en  = out_ready;
        busy      = 1'b1;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_loader_ctrl.sv
// Bench for data_loader_ctrl: models the datapath counter and a small x/y
// memory, scoreboards read-back data against what was loaded, and checks the
// controller outputs cycle by cycle from a vector table plus run-level counts.
module tb_data_loader_ctrl;

  localparam int NS = 150;
  localparam int NP = 4;
`ifdef DL_MULTI_PASS_EN
  localparam int EXP_PASSES = NP;
`else
  localparam int EXP_PASSES = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, co, init_cn, count_en;
  logic x_write, y_write, x_read, y_read, busy, done;
  logic [9:0] obs;

  data_loader_ctrl #(.N_SAMPLES(NS), .N_PASSES(NP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .co(co), .init_cn(init_cn), .count_en(count_en),
    .x_write(x_write), .y_write(y_write),
    .x_read(x_read), .y_read(y_read),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {in_ready, out_valid, init_cn, count_en, x_write, y_write,
                x_read, y_read, busy, done};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // datapath model: counter, terminal flag, memory
  int         cnt;
  logic [7:0] mem [NS];
  logic [7:0] in_data = 8'h00;
  assign co = (cnt == NS - 1);

  always @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= 0;
    else if (init_cn)  cnt <= 0;
    else if (count_en) cnt <= (cnt == NS - 1) ? 0 : cnt + 1;
  end

  // scoreboard and run statistics
  logic [7:0] load_data [$];
  logic [7:0] exp_q [$];
  int n_wr, n_hs, n_rdinit, n_init, n_done;
  int cyc = 0;
  int last_hs_cyc, done_cyc;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (busy) begin
        check("rdy_vld_excl", int'(in_ready && out_valid), 0);
        check("wr_rd_excl", int'(x_write && x_read), 0);
      end
      if (in_ready) check("load_count_en", int'(count_en), int'(in_valid));
      if (x_read)   check("read_count_en", int'(count_en), int'(out_ready));
      if (x_write) begin
        mem[cnt] = in_data;
        load_data.push_back(in_data);
        n_wr++;
      end
      if (init_cn) begin
        if (load_data.size() > 0) begin
          n_rdinit++;
          foreach (load_data[i]) exp_q.push_back(load_data[i]);
        end else begin
          n_init++;
        end
      end
      if (out_valid && out_ready) begin
        n_hs++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_data", int'(mem[cnt]), int'(exp_q.pop_front()));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    n_wr = 0; n_hs = 0; n_rdinit = 0; n_init = 0; n_done = 0;
    last_hs_cyc = 0; done_cyc = 0;
    load_data.delete();
    exp_q.delete();
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Feed samples until NS have been written; optional gap after gap_after.
  task automatic do_load(input int gap_after, input int gap_len);
    int gap = 0;
    int b = 0;
    while (n_wr < NS && b < 2000) begin
      @(negedge clk);
      in_data = 8'($urandom);
      if (n_wr == gap_after && gap < gap_len) begin
        in_valid = 1'b0;
        gap++;
        if (gap == gap_len) check("gap_no_write", n_wr, gap_after);
      end else begin
        in_valid = 1'b1;
      end
      b++;
    end
    in_valid = 1'b0;
    check("load_budget", int'(b < 2000), 1);
  endtask

  // Drain read passes until done; mode 0 = always ready, 1 = toggling.
  task automatic do_read(input int mode);
    int b = 0;
    while (n_done == 0 && b < 5000) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : b[0];
      b++;
    end
    out_ready = 1'b0;
    check("read_budget", int'(b < 5000), 1);
  endtask

  task automatic end_checks();
    check("writes", n_wr, NS);
    check("handshakes", n_hs, NS * EXP_PASSES);
    check("rd_init_pulses", n_rdinit, EXP_PASSES);
    check("init_pulses", n_init, 1);
    check("done_pulses", n_done, 1);
    check("done_latency", done_cyc - last_hs_cyc, 1);
    check("sb_left", exp_q.size(), 0);
    #1 check("idle_after_done", int'(obs), 0);
  endtask

  typedef struct packed {
    logic       start;
    logic       iv;
    logic       ordy;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl [7];

  initial begin
    // outputs: in_ready out_valid init_cn count_en x_write y_write x_read y_read busy done
    tbl[0] = '{1'b0, 1'b0, 1'b0, 10'b0000000000}; // idle
    tbl[1] = '{1'b1, 1'b0, 1'b0, 10'b0000000000}; // idle, start seen at edge
    tbl[2] = '{1'b0, 1'b0, 1'b0, 10'b0010000010}; // init
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10'b1000000010}; // load, stalled
    tbl[4] = '{1'b0, 1'b1, 1'b0, 10'b1001110010}; // load, beat
    tbl[5] = '{1'b1, 1'b1, 1'b0, 10'b1001110010}; // load, start ignored
    tbl[6] = '{1'b0, 1'b0, 1'b1, 10'b1000000010}; // load, stalled

    clear_stats();
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", int'(obs), 0);
    @(negedge clk); rst = 1'b1;

    // run 1: table-driven start, then full load and ready read
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start     = tbl[i].start;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = 8'($urandom);
      #1 check($sformatf("vec%0d", i), int'(obs), int'(tbl[i].exp));
    end
    start = 1'b0;
    out_ready = 1'b0;
    do_load(-1, 0);
    #1 check("rd_init_after_load", int'({init_cn, in_ready, x_write}), 3'b100);
    @(negedge clk);
    #1 check("first_out_valid", int'(out_valid), 1);
    do_read(0);
    end_checks();

    // run 2: upstream gap of 7 after sample 10, toggling downstream ready
    clear_stats();
    start_run();
    do_load(10, 7);
    do_read(1);
    end_checks();

    // run 3: reset in the middle of a read pass
    clear_stats();
    start_run();
    do_load(-1, 0);
    repeat (20) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    rst = 1'b0;
    #1 check("mid_read_reset_outputs", int'(obs), 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("idle_after_reset", int'(obs), 0);
    check("no_done_after_reset", n_done, 0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
